// File: rtl/instr_encoder_if.sv
// Handshake bundle for instr_encoder: mnemonic/field producer side and
// encoded-word consumer side.
interface instr_encoder_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_mnem;
  logic [4:0]       in_rs;
  logic [4:0]       in_rt;
  logic [4:0]       in_rd;
  logic [5:0]       in_funct;
  logic [15:0]      in_imm;
  logic [25:0]      in_target;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_instr;
  logic [WIDTH-1:0] out_addr;
  logic             illegal;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, in_mnem, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, illegal, count
  );

  modport slave (
    input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_funct, in_imm, in_target, out_ready,
    output in_ready, out_valid, out_instr, out_addr, illegal, count
  );
endinterface

// File: rtl/instr_encoder.sv
// Encodes mnemonic + fields into 32-bit instruction words and buffers them
// in a small FIFO, tagging each popped word with a running byte address.
module instr_encoder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  instr_encoder_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [3:0] M_RTYPE = 4'd0;
  localparam logic [3:0] M_LW    = 4'd1;
  localparam logic [3:0] M_SW    = 4'd2;
  localparam logic [3:0] M_ADDI  = 4'd3;
  localparam logic [3:0] M_SUBI  = 4'd4;
  localparam logic [3:0] M_BEQ   = 4'd5;
  localparam logic [3:0] M_J     = 4'd6;
  localparam logic [3:0] M_JAL   = 4'd7;
  localparam logic [3:0] M_JR    = 4'd8;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] word;
  logic             legal;
  logic             accept;
  logic             push;
  logic             pop;

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (bus.in_mnem)
      M_RTYPE: word = {6'd0, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, bus.in_funct};
      M_JR:    word = {6'd0, bus.in_rs, 5'd0, 5'd0, 5'd0, 6'b001000};
      M_LW:    word = {6'd1, bus.in_rs, bus.in_rt, bus.in_imm};
      M_SW:    word = {6'd2, bus.in_rs, bus.in_rt, bus.in_imm};
      M_ADDI:  word = {6'd3, bus.in_rs, bus.in_rt, bus.in_imm};
      M_SUBI:  word = {6'd4, bus.in_rs, bus.in_rt, bus.in_imm};
      M_BEQ:   word = {6'd5, bus.in_rs, bus.in_rt, bus.in_imm};
      M_J:     word = {6'd7, bus.in_target};
      M_JAL:   word = {6'd8, bus.in_target};
      default: legal = 1'b0;
    endcase
  end

  // Readiness is purely occupancy-based so the producer never sees a
  // combinational path from out_ready.
  assign bus.in_ready  = (count_q < CW'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign bus.out_instr = mem_q[rd_ptr_q];
  assign bus.out_addr  = addr_q;
  assign bus.illegal   = illegal_q;
  assign bus.count     = count_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign push   = accept & legal;
  assign pop    = bus.out_valid & bus.out_ready;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    addr_d    = addr_q;
    illegal_d = accept & ~legal;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      addr_d   = addr_q + WIDTH'(4);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      addr_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      addr_q    <= addr_d;
      illegal_q <= illegal_d;
    end
  end

  // Storage is deliberately left out of reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= word;
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder; inputs driven and outputs
// sampled on the falling edge.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  instr_encoder_if #(.WIDTH(32), .DEPTH(4)) bus ();
  instr_encoder #(.WIDTH(32), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  localparam logic [31:0] FULL_W [5] = '{32'h0C000001, 32'h0C200002, 32'h0C400003,
                                         32'h0C600004, 32'h0C800005};

  task automatic set_idle();
    bus.in_valid  = 1'b0;
    bus.in_mnem   = 4'd0;
    bus.in_rs     = 5'd0;
    bus.in_rt     = 5'd0;
    bus.in_rd     = 5'd0;
    bus.in_funct  = 6'd0;
    bus.in_imm    = 16'd0;
    bus.in_target = 26'd0;
    bus.out_ready = 1'b0;
  endtask

  task automatic drive(input logic [3:0] m, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] imm,
                       input logic [25:0] tgt);
    bus.in_valid  = 1'b1;
    bus.in_mnem   = m;
    bus.in_rs     = rs;
    bus.in_rt     = rt;
    bus.in_rd     = rd;
    bus.in_funct  = fn;
    bus.in_imm    = imm;
    bus.in_target = tgt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    set_idle();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (bus.count !== 3'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    tests_run++;
    if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    tests_run++;
    if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    tests_run++;
    if (bus.out_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_out_addr got %h exp 0", bus.out_addr); end
    tests_run++;
    if (bus.illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal got %b exp 0", bus.illegal); end
  endtask

  task automatic test_lw();
    do_reset();
    drive(4'd1, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0010, 26'd0);
    @(negedge clk);
    set_idle();
    tests_run++;
    if (bus.out_valid !== 1'b1) begin tests_failed++; $display("FAIL lw_valid got %b exp 1", bus.out_valid); end
    tests_run++;
    if (bus.out_instr !== 32'h04430010) begin tests_failed++; $display("FAIL lw_instr got %h exp 04430010", bus.out_instr); end
    tests_run++;
    if (bus.out_addr !== 32'h0) begin tests_failed++; $display("FAIL lw_addr got %h exp 0", bus.out_addr); end
    tests_run++;
    if (bus.count !== 3'd1) begin tests_failed++; $display("FAIL lw_count got %0d exp 1", bus.count); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL lw_pop count %0d valid %b exp 0 0", bus.count, bus.out_valid);
    end
    tests_run++;
    if (bus.out_addr !== 32'h4) begin tests_failed++; $display("FAIL lw_addr_after got %h exp 4", bus.out_addr); end
  endtask

  task automatic test_rtype_jr();
    do_reset();
    drive(4'd0, 5'd1, 5'd2, 5'd3, 6'b000111, 16'hFFFF, 26'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    drive(4'd8, 5'd31, 5'd5, 5'd6, 6'h3F, 16'hFFFF, 26'h3FFFFFF);
    tests_run++;
    if (bus.out_instr !== 32'h00221807) begin tests_failed++; $display("FAIL rtype_instr got %h exp 00221807", bus.out_instr); end
    tests_run++;
    if (bus.out_addr !== 32'h0) begin tests_failed++; $display("FAIL rtype_addr got %h exp 0", bus.out_addr); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.out_instr !== 32'h03E00008) begin tests_failed++; $display("FAIL jr_instr got %h exp 03E00008", bus.out_instr); end
    tests_run++;
    if (bus.out_addr !== 32'h4 || bus.count !== 3'd1) begin
      tests_failed++; $display("FAIL jr_addr_count got %h/%0d exp 4/1", bus.out_addr, bus.count);
    end
    @(negedge clk);
    set_idle();
    tests_run++;
    if (bus.count !== 3'd0 || bus.out_addr !== 32'h8) begin
      tests_failed++; $display("FAIL jr_drain got %0d/%h exp 0/8", bus.count, bus.out_addr);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (bus.in_ready !== (i < 4)) begin
        tests_failed++; $display("FAIL full_in_ready[%0d] got %b exp %b", i, bus.in_ready, (i < 4));
      end
      drive(4'd3, 5'(i), 5'd0, 5'd0, 6'd0, 16'(i + 1), 26'd0);
      @(negedge clk);
    end
    set_idle();
    tests_run++;
    if (bus.count !== 3'd4) begin tests_failed++; $display("FAIL full_count got %0d exp 4", bus.count); end
    tests_run++;
    if (bus.out_instr !== FULL_W[0]) begin tests_failed++; $display("FAIL full_hold got %h exp %h", bus.out_instr, FULL_W[0]); end
    bus.out_ready = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready_indep got %b exp 0", bus.in_ready); end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (bus.out_instr !== FULL_W[k] || bus.out_addr !== 32'(4 * k)) begin
        tests_failed++;
        $display("FAIL full_pop[%0d] got %h@%h exp %h@%h", k, bus.out_instr, bus.out_addr, FULL_W[k], 32'(4 * k));
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.count !== 3'd0 || bus.out_addr !== 32'h10) begin
      tests_failed++; $display("FAIL full_drain got %0d/%h exp 0/10", bus.count, bus.out_addr);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(4'd4, 5'd7, 5'd8, 5'd0, 6'd0, 16'h8000, 26'd0);
    @(negedge clk);
    tests_run++;
    if (bus.count !== 3'd1 || bus.illegal !== 1'b0) begin
      tests_failed++; $display("FAIL ill_pre got %0d/%b exp 1/0", bus.count, bus.illegal);
    end
    drive(4'd10, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1234, 26'h1);
    @(negedge clk);
    set_idle();
    tests_run++;
    if (bus.illegal !== 1'b1) begin tests_failed++; $display("FAIL ill_pulse got %b exp 1", bus.illegal); end
    tests_run++;
    if (bus.count !== 3'd1 || bus.out_valid !== 1'b1) begin
      tests_failed++; $display("FAIL ill_count got %0d/%b exp 1/1", bus.count, bus.out_valid);
    end
    tests_run++;
    if (bus.out_instr !== 32'h10E88000) begin tests_failed++; $display("FAIL ill_head got %h exp 10E88000", bus.out_instr); end
    @(negedge clk);
    tests_run++;
    if (bus.illegal !== 1'b0 || bus.count !== 3'd1) begin
      tests_failed++; $display("FAIL ill_after got %b/%0d exp 0/1", bus.illegal, bus.count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(4'd6, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0123456);
    @(negedge clk);
    drive(4'd7, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3ABCDEF);
    @(negedge clk);
    tests_run++;
    if (bus.count !== 3'd2 || bus.out_instr !== 32'h1C123456) begin
      tests_failed++; $display("FAIL b2b_pre got %0d/%h exp 2/1C123456", bus.count, bus.out_instr);
    end
    drive(4'd5, 5'd4, 5'd5, 5'd0, 6'd0, 16'hFFFF, 26'd0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests_run++;
    if (bus.count !== 3'd2) begin tests_failed++; $display("FAIL b2b_count got %0d exp 2", bus.count); end
    tests_run++;
    if (bus.out_instr !== 32'h23ABCDEF || bus.out_addr !== 32'h4) begin
      tests_failed++; $display("FAIL b2b_jal got %h@%h exp 23ABCDEF@4", bus.out_instr, bus.out_addr);
    end
    @(negedge clk);
    tests_run++;
    if (bus.out_instr !== 32'h1485FFFF || bus.out_addr !== 32'h8 || bus.count !== 3'd1) begin
      tests_failed++; $display("FAIL b2b_beq got %h@%h/%0d exp 1485FFFF@8/1", bus.out_instr, bus.out_addr, bus.count);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.count !== 3'd0 || bus.out_addr !== 32'hC) begin
      tests_failed++; $display("FAIL b2b_drain got %0d/%h exp 0/C", bus.count, bus.out_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'd0, 5'd1, 5'd1, 5'd1, 6'h20, 16'd0, 26'd0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    set_idle();
    tests_run++;
    if (bus.count !== 3'd3 || bus.out_addr !== 32'h8) begin
      tests_failed++; $display("FAIL mid_pre got %0d/%h exp 3/8", bus.count, bus.out_addr);
    end
    tests_run++;
    if (bus.out_instr !== 32'h00210820) begin tests_failed++; $display("FAIL mid_head got %h exp 00210820", bus.out_instr); end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (bus.count !== 3'd0 || bus.out_addr !== 32'h0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_async got %0d/%h/%b/%b exp 0/0/0/1", bus.count, bus.out_addr, bus.out_valid, bus.in_ready);
    end
    #1 reset = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.out_addr !== 32'h0) begin
      tests_failed++; $display("FAIL mid_after got %b/%h exp 0/0", bus.out_valid, bus.out_addr);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_lw();
    test_rtype_jr();
    test_full();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
